bi_mem_wm_arbiter: RTL and testbench

Round-robin arbiter that shares one write-masked single-port memory (`BiMemWm` interface) between `PORTS` requesters. Each requester drives a full memory request and holds it until granted; the arbiter selects one per cycle, forwards it to the memory, honours the memory's `hold` back-pressure, and routes returned read data back to the issuing requester. It sits between bus-side clients (DMA, core port, debug) and a `BiMemWm*` instance.

---
 rtl/bi_mem_wm_arbiter_if.sv | 42 ++++
 rtl/bi_mem_wm_arbiter.sv | 108 ++++++++++
 tb/tb_bi_mem_wm_arbiter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bi_mem_wm_arbiter_if.sv
// Requester and memory-side bundle for the round-robin BiMemWm arbiter.
// slave is the arbiter view; master is the clients-plus-memory view.
interface bi_mem_wm_arbiter_if #(
    parameter int PORTS  = 2,
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 16,
    parameter int MASK   = 4
);
    localparam int AW = $clog2(HEIGHT);

    logic [PORTS-1:0]       req_i;
    logic [PORTS-1:0]       isWrite_i;
    logic [PORTS*MASK-1:0]  writeMask_i;
    logic [PORTS*AW-1:0]    addr_i;
    logic [PORTS*WIDTH-1:0] writeData_i;
    logic [PORTS-1:0]       gnt_o;
    logic [PORTS-1:0]       rValid_o;
    logic [WIDTH-1:0]       readData_o;
    logic                   memEnable_o;
    logic                   memIsWrite_o;
    logic [MASK-1:0]        memWriteMask_o;
    logic [AW-1:0]          memAddr_o;
    logic [WIDTH-1:0]       memWriteData_o;
    logic [WIDTH-1:0]       memReadData_i;
    logic                   memHold_i;

    modport slave (
        input  req_i, isWrite_i, writeMask_i, addr_i, writeData_i,
        input  memReadData_i, memHold_i,
        output gnt_o, rValid_o, readData_o,
        output memEnable_o, memIsWrite_o, memWriteMask_o,
        output memAddr_o, memWriteData_o
    );

    modport master (
        output req_i, isWrite_i, writeMask_i, addr_i, writeData_i,
        output memReadData_i, memHold_i,
        input  gnt_o, rValid_o, readData_o,
        input  memEnable_o, memIsWrite_o, memWriteMask_o,
        input  memAddr_o, memWriteData_o
    );
endinterface

// File: rtl/bi_mem_wm_arbiter.sv
// Round-robin arbiter sharing one write-masked single-port memory.
// Locks the selected requester across memHold_i stalls; routes reads back.
module bi_mem_wm_arbiter #(
    parameter int PORTS   = 2,
    parameter int WIDTH   = 16,
    parameter int HEIGHT  = 16,
    parameter int MASK    = 4,
    parameter int LATENCY = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    bi_mem_wm_arbiter_if.slave bus
);
    localparam int AW = $clog2(HEIGHT);
    localparam int PW = $clog2(PORTS);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t          state;
    logic [PW-1:0]   prio;
    logic [PW-1:0]   lock_idx;
    logic [PW-1:0]   sel;
    logic [PW-1:0]   sel_hi;
    logic [PW-1:0]   sel_lo;
    logic            hit_hi;
    logic            any_req;
    logic            accept;
    logic [LATENCY-1:0] rp_valid;
    logic [PW-1:0]   rp_idx [LATENCY];

    // Lowest requester at or above prio, else lowest overall (the wrap).
    always_comb begin
        sel_hi = '0;
        sel_lo = '0;
        hit_hi = 1'b0;
        for (int j = PORTS - 1; j >= 0; j--) begin
            if (bus.req_i[j] && j >= int'(prio)) begin
                sel_hi = PW'(j);
                hit_hi = 1'b1;
            end
            if (bus.req_i[j]) begin
                sel_lo = PW'(j);
            end
        end
        if (rst_i) begin
            sel = '0;
        end else if (state == LOCKED) begin
            sel = lock_idx;
        end else begin
            sel = hit_hi ? sel_hi : sel_lo;
        end
    end

    assign any_req = (|bus.req_i) && !rst_i;
    assign accept  = any_req && !bus.memHold_i;

    assign bus.memEnable_o    = any_req;
    assign bus.memIsWrite_o   = bus.isWrite_i[sel];
    assign bus.memWriteMask_o = bus.writeMask_i[int'(sel)*MASK +: MASK];
    assign bus.memAddr_o      = bus.addr_i[int'(sel)*AW +: AW];
    assign bus.memWriteData_o = bus.writeData_i[int'(sel)*WIDTH +: WIDTH];
    assign bus.gnt_o          = accept ? (PORTS'(1) << sel) : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            prio     <= '0;
            lock_idx <= '0;
            rp_valid <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req && bus.memHold_i) begin
                        state    <= LOCKED;
                        lock_idx <= sel;
                    end
                end
                LOCKED: begin
                    if (accept) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (accept) begin
                prio <= (sel == PW'(PORTS - 1)) ? '0 : sel + 1'b1;
            end
            rp_valid[0] <= accept && !bus.memIsWrite_o;
            for (int k = 1; k < LATENCY; k++) begin
                rp_valid[k] <= rp_valid[k-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        rp_idx[0] <= sel;
        for (int k = 1; k < LATENCY; k++) begin
            rp_idx[k] <= rp_idx[k-1];
        end
    end

    assign bus.rValid_o = (rp_valid[LATENCY-1] && !rst_i)
                        ? (PORTS'(1) << rp_idx[LATENCY-1]) : '0;
    assign bus.readData_o = bus.memReadData_i;
endmodule

// File: tb/tb_bi_mem_wm_arbiter.sv
// Randomized bench for bi_mem_wm_arbiter with a request-level reference model.
// Bench also plays the role of the write-masked memory behind the arbiter.
module tb_bi_mem_wm_arbiter;
    localparam int PORTS   = 3;
    localparam int WIDTH   = 16;
    localparam int HEIGHT  = 16;
    localparam int MASK    = 4;
    localparam int LATENCY = 3;
    localparam int AW      = $clog2(HEIGHT);
    localparam int SEG     = WIDTH / MASK;
    localparam int NLOG    = 4096;

    typedef struct {
        int               due;
        int               port;
        logic [WIDTH-1:0] data;
    } ret_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   hold = 1'b0;
    bit   rnd  = 1'b0;
    int   cyc  = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    bi_mem_wm_arbiter_if #(
        .PORTS(PORTS), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .MASK(MASK)
    ) bus ();

    bi_mem_wm_arbiter #(
        .PORTS(PORTS), .WIDTH(WIDTH), .HEIGHT(HEIGHT),
        .MASK(MASK), .LATENCY(LATENCY)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

    bit               pend  [PORTS];
    bit               pw    [PORTS];
    logic [MASK-1:0]  pm    [PORTS];
    logic [AW-1:0]    pa    [PORTS];
    logic [WIDTH-1:0] pd    [PORTS];
    int               again [PORTS];

    logic [WIDTH-1:0] tmem  [HEIGHT];
    logic [WIDTH-1:0] gold  [HEIGHT];
    logic [WIDTH-1:0] rpipe [LATENCY];

    int   prio   = 0;
    bit   locked = 1'b0;
    int   lidx   = 0;
    ret_t rq[$];

    logic [31:0] lg_gnt [NLOG];
    logic [31:0] lg_rv  [NLOG];
    logic [31:0] lg_rd  [NLOG];
    logic [31:0] lg_en  [NLOG];
    logic [31:0] lg_adr [NLOG];
    logic [31:0] lg_eg  [NLOG];
    logic [31:0] lg_erv [NLOG];

    function automatic logic [WIDTH-1:0] merge(
        logic [WIDTH-1:0] old, logic [WIDTH-1:0] nw, logic [MASK-1:0] m);
        merge = old;
        for (int k = 0; k < MASK; k++)
            if (m[k]) merge[k*SEG +: SEG] = nw[k*SEG +: SEG];
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, exp);
        end
    endtask

    task automatic issue(int p, bit w, logic [MASK-1:0] m,
                         logic [AW-1:0] a, logic [WIDTH-1:0] d);
        pend[p]  = 1'b1;
        pw[p]    = w;
        pm[p]    = m;
        pa[p]    = a;
        pd[p]    = d;
        again[p] = 0;
    endtask

    task automatic drive();
        for (int p = 0; p < PORTS; p++) begin
            if (!pend[p]) begin
                pw[p] = 1'($urandom);
                pm[p] = MASK'($urandom);
                pa[p] = AW'($urandom);
                pd[p] = WIDTH'($urandom);
            end
            bus.req_i[p]                      = pend[p];
            bus.isWrite_i[p]                  = pw[p];
            bus.writeMask_i[p*MASK +: MASK]   = pm[p];
            bus.addr_i[p*AW +: AW]            = pa[p];
            bus.writeData_i[p*WIDTH +: WIDTH] = pd[p];
        end
        bus.memHold_i     = hold;
        bus.memReadData_i = rpipe[LATENCY-1];
    endtask

    task automatic step();
        int s;
        bit any, acc, found;
        logic [PORTS-1:0] eg, erv;
        logic [WIDTH-1:0] ed;
        drive();
        #3;
        any = 1'b0;
        for (int p = 0; p < PORTS; p++) if (pend[p]) any = 1'b1;
        if (rst) any = 1'b0;
        s = 0;
        found = 1'b0;
        if (any && locked) s = lidx;
        else if (any) begin
            for (int i = 0; i < PORTS; i++) begin
                if (!found && pend[(prio + i) % PORTS]) begin
                    s = (prio + i) % PORTS;
                    found = 1'b1;
                end
            end
        end
        acc = any && !hold;
        eg  = acc ? PORTS'(1 << s) : '0;
        erv = '0;
        ed  = '0;
        if (!rst && rq.size() > 0 && rq[0].due == cyc) begin
            erv = PORTS'(1 << rq[0].port);
            ed  = rq[0].data;
        end
        chk("gnt", 32'(bus.gnt_o), 32'(eg));
        chk("rvalid", 32'(bus.rValid_o), 32'(erv));
        chk("mem_en", 32'(bus.memEnable_o), 32'(any));
        if (any) begin
            chk("mem_we", 32'(bus.memIsWrite_o), 32'(pw[s]));
            chk("mem_addr", 32'(bus.memAddr_o), 32'(pa[s]));
            if (pw[s]) begin
                chk("mem_mask", 32'(bus.memWriteMask_o), 32'(pm[s]));
                chk("mem_wdata", 32'(bus.memWriteData_o), 32'(pd[s]));
            end
        end
        if (erv != '0) chk("rdata", 32'(bus.readData_o), 32'(ed));
        if (cyc < NLOG) begin
            lg_gnt[cyc] = 32'(bus.gnt_o);
            lg_rv[cyc]  = 32'(bus.rValid_o);
            lg_rd[cyc]  = 32'(bus.readData_o);
            lg_en[cyc]  = 32'(bus.memEnable_o);
            lg_adr[cyc] = 32'(bus.memAddr_o);
            lg_eg[cyc]  = 32'(eg);
            lg_erv[cyc] = 32'(erv);
        end
        @(posedge clk);
        for (int k = LATENCY - 1; k > 0; k--) rpipe[k] = rpipe[k-1];
        rpipe[0] = WIDTH'($urandom);
        if (bus.memEnable_o && !hold) begin
            if (bus.memIsWrite_o)
                tmem[bus.memAddr_o] = merge(tmem[bus.memAddr_o],
                    bus.memWriteData_o, bus.memWriteMask_o);
            else
                rpipe[0] = tmem[bus.memAddr_o];
        end
        if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
        if (rst) begin
            prio   = 0;
            locked = 1'b0;
            rq.delete();
        end else if (acc) begin
            prio   = (s + 1) % PORTS;
            locked = 1'b0;
            if (pw[s]) gold[pa[s]] = merge(gold[pa[s]], pd[s], pm[s]);
            else rq.push_back('{cyc + LATENCY, s, gold[pa[s]]});
            if (again[s] > 0) again[s]--;
            else pend[s] = 1'b0;
        end else if (any && hold) begin
            locked = 1'b1;
            lidx   = s;
        end
        if (rnd) begin
            for (int p = 0; p < PORTS; p++) begin
                if (!pend[p] && $urandom_range(0, 1) == 1)
                    issue(p, 1'($urandom), MASK'($urandom),
                          AW'($urandom), WIDTH'($urandom));
            end
        end
        cyc++;
        #1;
    endtask

    int t0, t1, t2, t3, t4, t5, tr, tc, tp;

    initial begin
        for (int i = 0; i < HEIGHT; i++) begin
            tmem[i] = '0;
            gold[i] = '0;
        end
        for (int k = 0; k < LATENCY; k++) rpipe[k] = '0;
        for (int p = 0; p < PORTS; p++) begin
            pend[p]  = 1'b0;
            again[p] = 0;
        end
        @(posedge clk);
        #1;
        issue(2, 1'b0, 4'h0, 4'd1, 16'h0);
        repeat (3) step();
        pend[2] = 1'b0;
        rst = 1'b0;

        t0 = cyc; issue(0, 1'b1, 4'hF, 4'd5, 16'hBEEF); step();
        t1 = cyc; issue(1, 1'b0, 4'h0, 4'd5, 16'h0); step();
        repeat (4) step();

        t2 = cyc; issue(2, 1'b1, 4'hF, 4'd7, 16'hFFFF); step();
        issue(0, 1'b1, 4'b0011, 4'd7, 16'h1234); step();
        t3 = cyc; issue(1, 1'b0, 4'h0, 4'd7, 16'h0); step();
        repeat (4) step();

        t4 = cyc;
        issue(0, 1'b0, 4'h0, 4'd3, 16'h0);
        issue(2, 1'b0, 4'h0, 4'd4, 16'h0);
        repeat (6) step();

        t5 = cyc; issue(0, 1'b0, 4'h0, 4'd5, 16'h0); hold = 1'b1; step();
        issue(1, 1'b0, 4'h0, 4'd7, 16'h0); step(); step();
        hold = 1'b0;
        repeat (6) step();

        tr = cyc; issue(2, 1'b0, 4'h0, 4'd5, 16'h0); step();
        rst = 1'b1; step(); rst = 1'b0;
        repeat (5) step();

        tc = cyc;
        for (int p = 0; p < PORTS; p++) begin
            issue(p, 1'b0, 4'h0, AW'(p), 16'h0);
            again[p] = 1;
        end
        repeat (9) step();

        tp = cyc;
        issue(0, 1'b0, 4'h0, 4'd5, 16'h0); again[0] = 1;
        issue(1, 1'b0, 4'h0, 4'd7, 16'h0); again[1] = 1;
        repeat (8) step();

        chk("rst_gnt", lg_gnt[1], 32'h0);
        chk("rst_en", lg_en[1], 32'h0);
        chk("rst_rv", lg_rv[1], 32'h0);
        chk("wr_gnt", lg_gnt[t0], 32'h1);
        chk("model_wr_gnt", lg_eg[t0], 32'h1);
        chk("rd_gnt", lg_gnt[t1], 32'h2);
        chk("rd_rv", lg_rv[t1+3], 32'h2);
        chk("rd_data", lg_rd[t1+3], 32'hBEEF);
        chk("model_rd_rv", lg_erv[t1+3], 32'h2);
        chk("mw_gnt_a", lg_gnt[t2], 32'h4);
        chk("mw_gnt_b", lg_gnt[t2+1], 32'h1);
        chk("mw_norv_a", lg_rv[t2+3], 32'h0);
        chk("mw_norv_b", lg_rv[t2+4], 32'h0);
        chk("mw_rd_gnt", lg_gnt[t3], 32'h2);
        chk("mw_rd_rv", lg_rv[t3+3], 32'h2);
        chk("mw_rd_data", lg_rd[t3+3], 32'hFF34);
        chk("pair_first", lg_gnt[t4], 32'h4);
        chk("pair_second", lg_gnt[t4+1], 32'h1);
        for (int k = 0; k < 3; k++) begin
            chk("lock_gnt", lg_gnt[t5+k], 32'h0);
            chk("lock_addr", lg_adr[t5+k], 32'd5);
            chk("lock_en", lg_en[t5+k], 32'h1);
        end
        chk("lock_release", lg_gnt[t5+3], 32'h1);
        chk("lock_next", lg_gnt[t5+4], 32'h2);
        chk("rstrd_gnt", lg_gnt[tr], 32'h4);
        for (int k = 1; k <= 5; k++) chk("rstrd_norv", lg_rv[tr+k], 32'h0);
        for (int k = 0; k < 6; k++)
            chk("rr_gnt", lg_gnt[tc+k], 32'(1 << (k % 3)));
        for (int k = 0; k < 4; k++) begin
            chk("pipe_rv", lg_rv[tp+3+k], (k % 2 == 0) ? 32'h1 : 32'h2);
            chk("pipe_data", lg_rd[tp+3+k],
                (k % 2 == 0) ? 32'hBEEF : 32'hFF34);
        end

        rnd = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            hold = ($urandom_range(0, 3) == 0);
            rst  = (i >= 1200 && i < 1202);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
